// File: rtl/shl32_iter_if.sv
// Start/done handshake bundle for the iterative left shifter/rotator.
// The master side issues operations and the slave side (the shifter) returns the result.
interface shl32_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_rol;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] num_shifts;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, op_rol, in, num_shifts,
    input  busy, done, out
  );

  modport slave (
    input  start, op_rol, in, num_shifts,
    output busy, done, out
  );
endinterface

// File: rtl/shl32_iter.sv
// Iterative 32-bit logical shift left / rotate left, one bit position per clock.
// Handshake: start is accepted in IDLE, and done pulses for one cycle with out already valid.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for start; operands captured on acceptance
//   S_SHIFT | one bit per cycle, cnt counts down to terminal count 1
//   S_DONE  | done=1 for one cycle, out holds the result
module shl32_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic            clock,
  input  logic            clear,
  shl32_iter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] wr;
  logic [WIDTH-1:0] wr_nxt;
  logic [WIDTH-1:0] out_r;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             rol;
  logic             rol_nxt;
  logic             sat;

  // Any amount above WIDTH-1 saturates SHL to zero; ROL ignores the upper bits.
  assign sat = |bus.num_shifts[WIDTH-1:CNT_W];

  always_comb begin
    state_nxt = state;
    wr_nxt    = wr;
    cnt_nxt   = cnt;
    rol_nxt   = rol;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          rol_nxt = bus.op_rol;
          wr_nxt  = bus.in;
          cnt_nxt = bus.num_shifts[CNT_W-1:0];
          if (!bus.op_rol && sat) begin
            wr_nxt    = '0;
            cnt_nxt   = '0;
            state_nxt = S_DONE;
          end else if (bus.num_shifts[CNT_W-1:0] == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        wr_nxt  = {wr[WIDTH-2:0], (rol ? wr[WIDTH-1] : 1'b0)};
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_IDLE;
      wr    <= '0;
      cnt   <= '0;
      rol   <= 1'b0;
      out_r <= '0;
    end else begin
      state <= state_nxt;
      wr    <= wr_nxt;
      cnt   <= cnt_nxt;
      rol   <= rol_nxt;
      // Load the result on the edge entering DONE so it is valid alongside done.
      if (state_nxt == S_DONE) begin
        out_r <= wr_nxt;
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);
  assign bus.out  = out_r;

endmodule

// File: tb/tb_shl32_iter.sv
// Directed and model-checked bench for the iterative left shifter/rotator.
module tb_shl32_iter;

  logic clock = 1'b0;
  logic clear;

  always #5 clock = ~clock;

  shl32_iter_if #(.WIDTH(32)) bus ();

  shl32_iter #(.WIDTH(32), .CNT_W(5)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Called one step after an edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic rol, input logic [31:0] x,
                        input logic [31:0] n, input logic [31:0] exp_out, input int exp_lat);
    int lat;
    lat = 0;
    bus.start      = 1'b1;
    bus.op_rol     = rol;
    bus.in         = x;
    bus.num_shifts = n;
    tick();
    bus.start      = 1'b0;
    bus.op_rol     = 1'($urandom);
    bus.in         = $urandom;
    bus.num_shifts = $urandom;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done) begin
        lat = k;
        break;
      end
      check({tag, ".busy_wait"}, 32'(bus.busy), 32'd1);
      tick();
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".out"}, bus.out, exp_out);
    check({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
    tick();
    check({tag, ".done_after"}, 32'(bus.done), 32'd0);
    check({tag, ".busy_after"}, 32'(bus.busy), 32'd0);
    check({tag, ".out_hold"}, bus.out, exp_out);
  endtask

  initial begin
    int dones;
    logic [31:0] x, n, expv;
    logic [63:0] dbl;
    logic        r;
    int          lat;

    bus.start      = 1'b0;
    bus.op_rol     = 1'b0;
    bus.in         = '0;
    bus.num_shifts = '0;
    clear          = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.out", bus.out, 32'd0);

    run_op("shl4", 1'b0, 32'h0000_0001, 32'd4, 32'h0000_0010, 5);

    // Abort a long SHL with clear; out must drop to zero and no done may follow.
    bus.start      = 1'b1;
    bus.op_rol     = 1'b0;
    bus.in         = 32'hA5A5_0001;
    bus.num_shifts = 32'd20;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    check("clr.busy", 32'(bus.busy), 32'd0);
    check("clr.done", 32'(bus.done), 32'd0);
    check("clr.out", bus.out, 32'd0);
    dones = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done) dones++;
      tick();
    end
    check("clr.no_done", 32'(dones), 32'd0);
    run_op("post_clr", 1'b0, 32'h0000_0003, 32'd2, 32'h0000_000C, 3);

    run_op("rol1", 1'b1, 32'h8000_0001, 32'd1, 32'h0000_0003, 2);
    run_op("rol36", 1'b1, 32'h1234_5678, 32'd36, 32'h2345_6781, 5);
    run_op("shl32_sat", 1'b0, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 1);
    run_op("shl0", 1'b0, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1);
    run_op("shl31", 1'b0, 32'h0000_0003, 32'd31, 32'h8000_0000, 32);
    run_op("rol32", 1'b1, 32'hCAFE_F00D, 32'd32, 32'hCAFE_F00D, 1);
    run_op("rol31", 1'b1, 32'h0000_0001, 32'd31, 32'h8000_0000, 32);
    run_op("shl_big", 1'b0, 32'h1234_5678, 32'h8000_0001, 32'h0000_0000, 1);

    // Extra start pulses during SHIFT and DONE of a shift-by-3 must be ignored.
    bus.start      = 1'b1;
    bus.op_rol     = 1'b0;
    bus.in         = 32'h0000_00F0;
    bus.num_shifts = 32'd3;
    tick();
    bus.start = 1'b0;
    tick();
    bus.start      = 1'b1;
    bus.in         = 32'h0000_FFFF;
    bus.num_shifts = 32'd1;
    tick();
    bus.start = 1'b0;
    check("ign.no_early_done", 32'(bus.done), 32'd0);
    tick();
    check("ign.done", 32'(bus.done), 32'd1);
    check("ign.out", bus.out, 32'h0000_0780);
    bus.start      = 1'b1;
    bus.in         = 32'h0000_0001;
    bus.num_shifts = 32'd1;
    tick();
    bus.start = 1'b0;
    check("ign.idle_busy", 32'(bus.busy), 32'd0);
    check("ign.idle_done", 32'(bus.done), 32'd0);
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.done) dones++;
      tick();
    end
    check("ign.single_done", 32'(dones), 32'd0);
    check("ign.out_hold", bus.out, 32'h0000_0780);

    // Random operations against a shift/rotate reference.
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      r = 1'($urandom);
      n = (i % 3 == 0) ? $urandom : $urandom_range(0, 40);
      if (r) begin
        dbl  = {x, x} << n[4:0];
        expv = dbl[63:32];
        lat  = int'(n[4:0]) + 1;
      end else if (n > 32'd31) begin
        expv = 32'd0;
        lat  = 1;
      end else begin
        expv = x << n;
        lat  = int'(n) + 1;
      end
      run_op($sformatf("rnd%0d", i), r, x, n, expv, lat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
